song_recorder: RTL and testbench
================================

# song_recorder

Captures live key presses from the piano switches into an on-chip song memory as note/octave/duration entries. It is the writer-side counterpart of the auto/learn playback path and is armed by `write_on`. The top-level playback logic reads the recorded song back through a registered read port. The block sits beside the mode controller and shares its key, octave and note encodings.

## Interface
Parameters:
- `TICK_CYCLES`, 12_500_000 — clock cycles per duration unit (125 ms at 100 MHz)
- `DEPTH`, 64 — number of song entries; power of two
- `ADDR_W`, 6 — log2(DEPTH)

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` input 1 — system clock
- `reset` input 1 — synchronous, active-high
- `write_on` input 1 — recording enable switch (asynchronous)
- `keys` input 7 — note switches, bit 0 = do … bit 6 = ti (asynchronous)
- `octave` input 2 — current octave selection (asynchronous)
- `rd_addr` input ADDR_W — playback read address
- `rd_data` output 10 — {note[3:0], octave[1:0], dur[3:0]}
- `length` output ADDR_W+1 — number of valid entries
- `recording` output 1 — high while in REC
- `full` output 1 — memory filled during the last recording

## Operation
- `keys`, `octave` and `write_on` pass through 2-flop synchronizers. All behaviour below uses synchronized values.
- Note encoding: the lowest set bit of `keys` gives note index+1 (1..7). All-zero `keys` gives 0 (rest). Example: `keys`=7'b0000101 gives note 1.
- An "event" is the current {note, octave} pair plus a 4-bit `dur` and a prescaler counting 0..TICK_CYCLES-1. Each prescaler wrap is one tick and increments `dur`.
- FSM states:
  - IDLE: waits for a `write_on` 0→1 edge. On the edge: `length`<=0, `full`<=0, load the event from the current sample, `dur`<=0, prescaler<=0, go to REC.
  - REC:
    - sample ≠ event: flush, then load the new event with `dur` and prescaler cleared.
    - tick with `dur`==15: flush with dur 15, then restart the same note with `dur`<=0.
    - `write_on` falls: flush, then go to IDLE.
  - DONE: entered when `length` reaches DEPTH. Ignores keys; returns to IDLE when `write_on` is 0.
- Flush writes {note, octave, dur} at address `length` and increments `length`. A flush with `dur`==0 is discarded: sub-tick glitches are not stored.
- Rests, including a leading rest, are recorded as note 0.
- `full` is set on entry to DONE and held until the next arm.
- Memory contents are never cleared, including by reset. Only `length` defines validity.

## Timing
- Input-to-FSM latency is 2 cycles, identical for all inputs, so recorded durations are unaffected.
- Memory write occurs in the same cycle as flush detection. `length` updates the following cycle.
- `rd_data` is registered with 1-cycle read latency. A read and write to the same address in the same cycle returns the old data.
- Change and saturation in the same cycle: change wins. Flush the old event with its current `dur` (15 if that tick completes it, capped).
- `write_on` falling together with a change: perform one flush of the old event only, then go to IDLE.
- Flush that makes `length`==DEPTH goes to DONE, even if `write_on` falls in the same cycle.
- Reset values: state IDLE, `length` 0, `recording` 0, `full` 0, `rd_data` 0, synchronizers 0.
- Reset mid-recording aborts the take. Re-arming requires a fresh `write_on` 0→1 edge after reset.

## Structure
- Shared package: note encoding constants (REST=0, DO=1..TI=7), the entry field widths and packing order, and the FSM state enum. The playback side uses the same package.
- One sub-module, `song_ram`: single write port, registered read port, DEPTH×10, no reset on the array.

## Test plan
Bench uses `TICK_CYCLES`=4, `DEPTH`=4.
- Reset → `length`=0, `recording`=0, `full`=0, `rd_data`=0.
- Arm; hold `keys`=7'b0000001, `octave`=01 for 12 cycles; rest for 8 cycles; drop `write_on` → `length`=2. Entry0={1,01,3}, entry1={0,01,2}.
- During REC, apply a 2-cycle pulse of `keys`=7'b0000100 inside a rest → no note-3 entry stored.
- Hold `keys`=7'b1000000 for 70 cycles, then drop `write_on` → entries {7,oct,15} and {7,oct,2}.
- Change keys every 4 cycles for 8 changes → after 4 entries: `full`=1, `recording`=0, `length`=4, later changes ignored. Dropping then re-raising `write_on` clears `full`.
- Assert `reset` mid-REC → `length`=0 and IDLE. Holding `write_on` high after reset does not start recording until it toggles 0→1.

Source files
------------

// File: rtl/song_recorder_pkg.sv
// Shared definitions for the song recorder and the playback path:
// note encoding, entry field layout and the recorder FSM states.
package song_recorder_pkg;

  localparam int NOTE_W  = 4;
  localparam int OCT_W   = 2;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = NOTE_W + OCT_W + DUR_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_DO   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_FA   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_SO   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_LA   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_TI   = 4'd7;

  localparam logic [DUR_W-1:0] DUR_MAX = 4'd15;

  // Entry packing, MSB first: {note, octave, dur}
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REC,
    ST_DONE
  } rec_state_e;

  // Lowest set key wins; no key pressed is a rest.
  function automatic logic [NOTE_W-1:0] key_to_note(input logic [6:0] key_vec);
    logic [NOTE_W-1:0] n;
    n = NOTE_REST;
    for (int i = 6; i >= 0; i--) begin
      if (key_vec[i]) n = NOTE_W'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/song_recorder_if.sv
// Playback-facing port of the song recorder: read address in,
// registered entry data and take status out.
interface song_recorder_if #(
  parameter int ADDR_W = 6
);
  import song_recorder_pkg::*;

  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic [ADDR_W:0]    length;
  logic               recording;
  logic               full;

  // Playback side drives the address and consumes the rest
  modport master (
    output rd_addr,
    input  rd_data, length, recording, full
  );

  // Recorder side
  modport slave (
    input  rd_addr,
    output rd_data, length, recording, full
  );

endinterface

// File: rtl/song_ram.sv
// Song memory: one write port, one registered read-first read port.
// The array itself is never reset so a take survives a reset.
module song_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents persist across reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; a same-address write in this cycle is not visible yet
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/song_recorder.sv
// Records live key presses into song memory as {note, octave, dur}
// entries while write_on is armed. Durations are counted in ticks of
// TICK_CYCLES clocks; a note longer than 15 ticks is split into entries.
module song_recorder
  import song_recorder_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_on,
  input  logic [6:0] keys,
  input  logic [1:0] octave,
  song_recorder_if.slave bus
);

  localparam int PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W:0]    LEN_LAST   = (ADDR_W + 1)'(DEPTH - 1);
  localparam int SYNC_W = 10;

  // Synchronizer chains for {write_on, octave, keys}
  logic [SYNC_W-1:0] sync_s1_reg;
  logic [SYNC_W-1:0] sync_s2_reg;

  // write_on edge detection; held until the synchronizer refills after reset
  logic [1:0] settle_reg;
  logic       wo_prev_reg;

  rec_state_e        state_reg, state_next;
  logic [NOTE_W-1:0] ev_note_reg, ev_note_next;
  logic [OCT_W-1:0]  ev_oct_reg, ev_oct_next;
  logic [DUR_W-1:0]  dur_reg, dur_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [ADDR_W:0]   length_reg, length_next;
  logic              full_reg, full_next;

  logic [6:0]        keys_s;
  logic [OCT_W-1:0]  oct_s;
  logic              wo_s;
  logic              wo_rise;
  logic [NOTE_W-1:0] note_s;
  logic              changed;
  logic              tick;
  logic              flush;
  logic [DUR_W-1:0]  flush_dur;
  logic              wr_en;
  entry_t            wr_entry;

  // Two-flop synchronizers, all inputs share the same latency
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_s1_reg <= '0;
      sync_s2_reg <= '0;
    end else begin
      sync_s1_reg <= {write_on, octave, keys};
      sync_s2_reg <= sync_s1_reg;
    end
  end

  assign keys_s = sync_s2_reg[6:0];
  assign oct_s  = sync_s2_reg[8:7];
  assign wo_s   = sync_s2_reg[9];
  assign note_s = key_to_note(keys_s);

  // Previous write_on; treated as high after reset so a switch left on
  // must be toggled off and on again before a new take starts
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_reg  <= 2'b00;
      wo_prev_reg <= 1'b1;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
      if (settle_reg[1]) wo_prev_reg <= wo_s;
    end
  end

  assign wo_rise = wo_s & ~wo_prev_reg;
  assign changed = (note_s != ev_note_reg) || (oct_s != ev_oct_reg);
  assign tick    = (presc_reg == PRESC_LAST);

  // FSM and event state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ev_note_reg <= NOTE_REST;
      ev_oct_reg  <= '0;
      dur_reg     <= '0;
      presc_reg   <= '0;
      length_reg  <= '0;
      full_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ev_note_reg <= ev_note_next;
      ev_oct_reg  <= ev_oct_next;
      dur_reg     <= dur_next;
      presc_reg   <= presc_next;
      length_reg  <= length_next;
      full_reg    <= full_next;
    end
  end

  // Next-state logic: event timing, flush decisions, memory fill
  always_comb begin
    state_next   = state_reg;
    ev_note_next = ev_note_reg;
    ev_oct_next  = ev_oct_reg;
    dur_next     = dur_reg;
    presc_next   = presc_reg;
    length_next  = length_reg;
    full_next    = full_reg;
    flush        = 1'b0;
    flush_dur    = dur_reg;

    case (state_reg)
      ST_IDLE: begin
        if (wo_rise) begin
          length_next  = '0;
          full_next    = 1'b0;
          ev_note_next = note_s;
          ev_oct_next  = oct_s;
          dur_next     = '0;
          presc_next   = '0;
          state_next   = ST_REC;
        end
      end
      ST_REC: begin
        // A tick landing in this cycle counts toward the event being flushed
        flush_dur  = (tick && dur_reg != DUR_MAX) ? dur_reg + 1'b1 : dur_reg;
        presc_next = tick ? '0 : presc_reg + 1'b1;
        dur_next   = flush_dur;
        if (!wo_s) begin
          flush      = 1'b1;
          state_next = ST_IDLE;
        end else if (changed) begin
          flush        = 1'b1;
          ev_note_next = note_s;
          ev_oct_next  = oct_s;
          dur_next     = '0;
          presc_next   = '0;
        end else if (flush_dur == DUR_MAX) begin
          flush    = 1'b1;
          dur_next = '0;
        end
      end
      ST_DONE: begin
        if (!wo_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Zero-length events are glitches and never reach memory
    wr_en = flush && (flush_dur != '0);
    if (wr_en) begin
      length_next = length_reg + 1'b1;
      if (length_reg == LEN_LAST) begin
        state_next = ST_DONE;
        full_next  = 1'b1;
      end
    end
  end

  assign wr_entry = '{note: ev_note_reg, octave: ev_oct_reg, dur: flush_dur};

  song_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (length_reg[ADDR_W-1:0]),
    .wr_data (wr_entry),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.length    = length_reg;
  assign bus.recording = (state_reg == ST_REC);
  assign bus.full      = full_reg;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with short ticks and a 4-entry memory.
module tb_song_recorder;

  localparam int TICK   = 4;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       write_on;
  logic [6:0] keys;
  logic [1:0] octave;

  int n_checks = 0;
  int n_fail   = 0;

  song_recorder_if #(.ADDR_W(ADDR_W)) bus ();

  song_recorder #(
    .TICK_CYCLES (TICK),
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .write_on (write_on),
    .keys     (keys),
    .octave   (octave),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance n clocks and land 1 time unit after the last rising edge
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] ent(input logic [3:0] n, input logic [1:0] o, input logic [3:0] d);
    return {n, o, d};
  endfunction

  task automatic check_entry(input string tag, input logic [1:0] addr, input logic [9:0] exp);
    bus.rd_addr = addr;
    cycles(1);
    check_eq(tag, 16'(bus.rd_data), 16'(exp));
  endtask

  task automatic check_status(input string tag, input int len, input logic rec, input logic fl);
    check_eq({tag, ".length"},    16'(bus.length),    16'(len));
    check_eq({tag, ".recording"}, 16'(bus.recording), 16'(rec));
    check_eq({tag, ".full"},      16'(bus.full),      16'(fl));
  endtask

  logic [6:0] seq [8];

  initial begin
    seq = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000,
            7'b0100000, 7'b1000000, 7'b0000001, 7'b0000010};

    reset = 1'b1; write_on = 1'b0; keys = '0; octave = '0; bus.rd_addr = '0;
    cycles(3);
    check_status("reset", 0, 1'b0, 1'b0);
    check_eq("reset.rd_data", 16'(bus.rd_data), 16'h0);
    reset = 1'b0;
    cycles(3);

    // Take 1: do/oct1 for 12 cycles (3 ticks), rest 8 cycles (2 ticks)
    keys = 7'b0000001; octave = 2'b01;
    cycles(3);
    write_on = 1'b1;
    cycles(12);
    keys = '0;
    cycles(8);
    write_on = 1'b0;
    cycles(5);
    check_status("take1", 2, 1'b0, 1'b0);
    check_entry("take1.e0", 2'd0, ent(4'd1, 2'b01, 4'd3));
    check_entry("take1.e1", 2'd1, ent(4'd0, 2'b01, 4'd2));

    // Take 2: leading rest with a 2-cycle mi glitch inside it
    keys = '0; octave = 2'b10;
    cycles(3);
    write_on = 1'b1;
    cycles(8);
    keys = 7'b0000100;
    cycles(2);
    keys = '0;
    cycles(8);
    write_on = 1'b0;
    cycles(5);
    check_eq("take2.length", 16'(bus.length), 16'd2);
    check_entry("take2.e0", 2'd0, ent(4'd0, 2'b10, 4'd2));
    check_entry("take2.e1", 2'd1, ent(4'd0, 2'b10, 4'd2));

    // Take 3: ti held 70 cycles splits at 15 ticks
    keys = 7'b1000000; octave = 2'b11;
    cycles(3);
    write_on = 1'b1;
    cycles(70);
    write_on = 1'b0;
    cycles(5);
    check_eq("take3.length", 16'(bus.length), 16'd2);
    check_entry("take3.e0", 2'd0, ent(4'd7, 2'b11, 4'd15));
    check_entry("take3.e1", 2'd1, ent(4'd7, 2'b11, 4'd2));

    // Take 4: a new key every 4 cycles fills the memory
    keys = 7'b0000001; octave = 2'b00;
    cycles(3);
    write_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycles(4);
      keys = seq[i];
    end
    cycles(6);
    check_status("take4", 4, 1'b0, 1'b1);
    check_entry("take4.e0", 2'd0, ent(4'd1, 2'b00, 4'd1));
    check_entry("take4.e1", 2'd1, ent(4'd2, 2'b00, 4'd1));
    check_entry("take4.e2", 2'd2, ent(4'd3, 2'b00, 4'd1));
    check_entry("take4.e3", 2'd3, ent(4'd4, 2'b00, 4'd1));
    write_on = 1'b0;
    cycles(5);
    check_status("take4.off", 4, 1'b0, 1'b1);

    // Re-arm clears full, then reset mid-take
    write_on = 1'b1;
    cycles(4);
    check_status("rearm", 0, 1'b1, 1'b0);
    keys = 7'b0000100;
    cycles(4);
    keys = 7'b0001000;
    cycles(4);
    check_eq("rearm.length", 16'(bus.length), 16'd2);
    reset = 1'b1;
    cycles(1);
    check_status("midreset", 0, 1'b0, 1'b0);
    check_eq("midreset.rd_data", 16'(bus.rd_data), 16'h0);
    reset = 1'b0;
    cycles(10);
    check_eq("held_high.recording", 16'(bus.recording), 16'd0);
    write_on = 1'b0;
    cycles(4);
    write_on = 1'b1;
    cycles(4);
    check_eq("toggle.recording", 16'(bus.recording), 16'd1);
    write_on = 1'b0;
    cycles(5);
    check_eq("final.recording", 16'(bus.recording), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
